// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiply/divide unit.
package ibex_pkg;

  // Operation encoding presented on op_i.
  typedef enum logic [2:0] {
    MdOpMul    = 3'd0,
    MdOpMulh   = 3'd1,
    MdOpMulhsu = 3'd2,
    MdOpMulhu  = 3'd3,
    MdOpDiv    = 3'd4,
    MdOpDivu   = 3'd5,
    MdOpRem    = 3'd6,
    MdOpRemu   = 3'd7
  } md_gen_op_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPrep    = 3'd1,
    StMulIter = 3'd2,
    StDivIter = 3'd3,
    StFix     = 3'd4,
    StDone    = 3'd5
  } md_gen_state_e;

  // Divide-class operations share bit 2 of the encoding.
  function automatic logic md_is_div(md_gen_op_e op);
    return op inside {MdOpDiv, MdOpDivu, MdOpRem, MdOpRemu};
  endfunction

endpackage

// File: rtl/ibex_multdiv_gen_mulstep.sv
// Combinational partial-product accumulate: acc + a * bits, MUL_BITS x WIDTH.
import ibex_pkg::*;

module ibex_multdiv_gen_mulstep #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic [WIDTH-1:0]          acc_i,
  input  logic [WIDTH-1:0]          a_i,
  input  logic [MUL_BITS-1:0]       bits_i,
  output logic [WIDTH+MUL_BITS-1:0] sum_o
);

  // Shift-and-add over the retired multiplier bits; cannot overflow WIDTH+MUL_BITS.
  always_comb begin
    sum_o = {{MUL_BITS{1'b0}}, acc_i};
    for (int i = 0; i < MUL_BITS; i++) begin
      if (bits_i[i]) begin
        sum_o = sum_o + ({{MUL_BITS{1'b0}}, a_i} << i);
      end
    end
  end

endmodule

// File: rtl/ibex_multdiv_gen.sv
// Iterative multiplier (MUL_BITS per cycle) and restoring divider (1 bit per cycle).
import ibex_pkg::*;

module ibex_multdiv_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned MulCycles = WIDTH / MUL_BITS;
  localparam int unsigned CntW      = 7;

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("WIDTH must be even and within 8..64");
  end
  if (!(MUL_BITS inside {1, 2, 4, 8}) || (WIDTH % MUL_BITS) != 0) begin : g_bad_mul_bits
    $error("MUL_BITS must be 1, 2, 4 or 8 and divide WIDTH");
  end

  md_gen_state_e      state_q, state_d;
  md_gen_op_e         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               dit_q, dit_d, neg_q, neg_d, neg_rem_q, neg_rem_d, b_zero_q, b_zero_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH+MUL_BITS-1:0]   mul_sum;
  logic [2*WIDTH+MUL_BITS-1:0] mul_cat;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ok;

  // Signedness is only meaningful in PREP, while a_q/b_q still hold raw operands.
  assign a_neg = (op_q inside {MdOpMulh, MdOpMulhsu, MdOpDiv, MdOpRem}) & a_q[WIDTH-1];
  assign b_neg = (op_q inside {MdOpMulh, MdOpDiv, MdOpRem}) & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;

  ibex_multdiv_gen_mulstep #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mulstep (
    .acc_i  (prod_q[2*WIDTH-1:WIDTH]),
    .a_i    (a_q),
    .bits_i (prod_q[MUL_BITS-1:0]),
    .sum_o  (mul_sum)
  );

  // prod_q = {accumulator, remaining multiplier bits}; shifts right each step.
  assign mul_cat = {mul_sum, prod_q[WIDTH-1:0]};

  // Divider: prod_q = {partial remainder, dividend/quotient}.
  assign quo       = prod_q[WIDTH-1:0];
  assign rem       = prod_q[2*WIDTH-1:WIDTH];
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign prod_fix  = neg_q ? -prod_q : prod_q;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dit_d     = dit_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid_i && !kill_i) begin
          op_d    = md_gen_op_e'(op_i);
          a_d     = op_a_i;
          b_d     = op_b_i;
          dit_d   = data_ind_timing_i;
          state_d = StPrep;
        end
      end
      StPrep: begin
        a_d       = a_mag;
        b_d       = b_mag;
        neg_d     = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        b_zero_d  = (b_q == '0);
        if (md_is_div(op_q)) begin
          prod_d = {{WIDTH{1'b0}}, a_mag};
          if (b_q == '0 && !dit_q) begin
            result_d = (op_q inside {MdOpDiv, MdOpDivu}) ? '1 : a_q;
            state_d  = StDone;
          end else begin
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StDivIter;
          end
        end else begin
          prod_d  = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = CntW'(MulCycles - 1);
          state_d = StMulIter;
        end
      end
      StMulIter: begin
        prod_d = mul_cat[2*WIDTH+MUL_BITS-1:MUL_BITS];
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDivIter: begin
        prod_d = {div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0], quo[WIDTH-2:0], div_ok};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StFix: begin
        unique case (op_q)
          MdOpMul:                       result_d = prod_fix[WIDTH-1:0];
          MdOpMulh, MdOpMulhsu, MdOpMulhu: result_d = prod_fix[2*WIDTH-1:WIDTH];
          MdOpDiv, MdOpDivu:             result_d = b_zero_q ? '1 : (neg_q ? -quo : quo);
          default:                       result_d = neg_rem_q ? -rem : rem;
        endcase
        state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) begin
          result_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any progress outside IDLE.
    if (kill_i && state_q != StIdle) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= MdOpMul;
      a_q       <= '0;
      b_q       <= '0;
      dit_q     <= 1'b0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dit_q     <= dit_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      result_q  <= result_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle) & ~kill_i;
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = (state_q == StDone);
  assign result_o    = out_valid_o ? result_q : '0;

endmodule

// File: tb/tb_ibex_multdiv_gen.sv
// Randomized and directed checks of ibex_multdiv_gen against an arithmetic model.
module tb_ibex_multdiv_gen;

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, data_ind_timing_i, kill_i;
  logic        out_valid_o, out_ready_i, busy_o;
  logic [2:0]  op_i;
  logic [31:0] op_a_i, op_b_i, result_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ibex_multdiv_gen #(
    .WIDTH    (32),
    .MUL_BITS (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .op_i              (op_i),
    .op_a_i            (op_a_i),
    .op_b_i            (op_b_i),
    .data_ind_timing_i (data_ind_timing_i),
    .kill_i            (kill_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .result_o          (result_o),
    .busy_o            (busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b, input logic dit);
    if (!op[2]) return 3 + 32 / 4;
    if (b == 32'd0 && !dit) return 2;
    return 3 + 32;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one operation, check latency and result, hold DONE for 'hold' cycles, then consume.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dit, input int hold, output logic [31:0] res);
    logic [31:0] exp_r;
    int exp_lat, lat, w;
    exp_r   = model(op, a, b);
    exp_lat = model_lat(op, b, dit);
    @(negedge clk);
    w = 0;
    while (!in_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_op", in_ready_o, 1);
    in_valid_i        = 1'b1;
    op_i              = op;
    op_a_i            = a;
    op_b_i            = b;
    data_ind_timing_i = dit;
    out_ready_i       = 1'b0;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; they must not leak into the result.
    in_valid_i        = 1'b0;
    op_i              = 3'($urandom);
    op_a_i            = $urandom;
    op_b_i            = $urandom;
    data_ind_timing_i = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("result", result_o, exp_r);
    res = result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_result", result_o, exp_r);
      check_eq("hold_ready", in_ready_o, 0);
      check_eq("hold_valid", out_valid_o, 1);
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    check_eq("idle_valid", out_valid_o, 0);
    check_eq("idle_ready", in_ready_o, 1);
    check_eq("idle_result", result_o, 0);
  endtask

  // Accept an operation without waiting for its result.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_eq("start_ready", in_ready_o, 1);
    in_valid_i = 1'b1;
    op_i       = op;
    op_a_i     = a;
    op_b_i     = b;
    data_ind_timing_i = 1'b0;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          seen;

    rst_i = 1'b1; in_valid_i = 1'b0; op_i = '0; op_a_i = '0; op_b_i = '0;
    data_ind_timing_i = 1'b0; kill_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", in_ready_o, 1);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_result", result_o, 0);

    // Directed cases.
    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 0, r);
    check_eq("mulh_dir", r, 32'hFFFF_FFFF);
    do_op(3'd0, 32'd3, 32'd5, 1'b0, 0, r);
    check_eq("mul_dir", r, 32'h0000_000F);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, r);
    check_eq("div_min", r, 32'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, r);
    check_eq("rem_min", r, 32'h0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, r);
    check_eq("rem_neg", r, 32'hFFFF_FFFF);
    do_op(3'd5, 32'h1234, 32'd0, 1'b0, 0, r);
    check_eq("divu_zero_fast", r, 32'hFFFF_FFFF);
    do_op(3'd5, 32'h1234, 32'd0, 1'b1, 0, r);
    check_eq("divu_zero_dit", r, 32'hFFFF_FFFF);
    do_op(3'd7, 32'h1234, 32'd0, 1'b0, 0, r);
    check_eq("remu_zero", r, 32'h1234);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b1, 0, r);
    check_eq("div_zero_neg", r, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, r);
    check_eq("mulhsu_hold", r, 32'hFFFF_FFFF);

    // Kill in IDLE blocks acceptance.
    @(negedge clk);
    kill_i = 1'b1; in_valid_i = 1'b1; op_i = 3'd0; op_a_i = 32'd7; op_b_i = 32'd7;
    #1 check_eq("kill_idle_ready", in_ready_o, 0);
    @(posedge clk);
    #1 in_valid_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    check_eq("kill_idle_busy", busy_o, 0);

    // Kill during the tenth divide iteration.
    start_op(3'd4, 32'h7654_3210, 32'd13);
    repeat (11) @(negedge clk);
    check_eq("kill_div_busy", busy_o, 1);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    check_eq("kill_div_ready", in_ready_o, 1);
    check_eq("kill_div_valid", out_valid_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= out_valid_o;
    end
    check_eq("kill_no_valid", seen, 0);
    do_op(3'd0, 32'd3, 32'd5, 1'b0, 0, r);
    check_eq("mul_after_kill", r, 32'h0000_000F);

    // Reset mid multiply, with kill and result-ready asserted alongside.
    start_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (4) @(negedge clk);
    rst_i = 1'b1; kill_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0; kill_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_valid", out_valid_o, 0);
    check_eq("midrst_result", result_o, 0);
    check_eq("midrst_ready", in_ready_o, 1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, r);
    check_eq("mulhu_after_rst", r, 32'hFFFF_FFFE);

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      do_op(op, a, b, 1'($urandom), int'($urandom_range(0, 2)), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
